// File: rtl/cnt_clk_pkg.sv
// cnt_clk_pkg: shared types and constants for the divided-clock receiver.
// State encoding, select codes, tick counter width, expected interval.
package cnt_clk_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SYNC,
    TRACK
  } state_e;

  localparam logic [1:0] CKS_DIV2  = 2'd0;
  localparam logic [1:0] CKS_DIV4  = 2'd1;
  localparam logic [1:0] CKS_DIV8  = 2'd2;
  localparam logic [1:0] CKS_DIV16 = 2'd3;

  localparam int TCNT_W = 8;

  function automatic logic [5:0] exp_interval(input logic [1:0] cks);
    logic [5:0] e;
    e = 6'd2;
    unique case (cks)
      CKS_DIV2:  e = 6'd2;
      CKS_DIV4:  e = 6'd4;
      CKS_DIV8:  e = 6'd8;
      CKS_DIV16: e = 6'd16;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/cnt_clk_in_sync.sv
// cnt_clk_in_sync: multi-stage synchronizer for the 4-bit divided-clock bus,
// followed by a previous-value flop giving per-bit rising-edge strobes.
module cnt_clk_in_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [3:0] line_i,
  output logic [3:0] sync_o,
  output logic [3:0] edge_o
);

  logic [3:0] st_q [SYNC_STAGES];
  logic [3:0] prev_q;

  // Synchronizer chain and previous-value flop, all bits always running
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < SYNC_STAGES; i++) st_q[i] <= '0;
      prev_q <= '0;
    end else begin
      st_q[0] <= line_i;
      for (int i = 1; i < SYNC_STAGES; i++) st_q[i] <= st_q[i-1];
      prev_q <= st_q[SYNC_STAGES-1];
    end
  end

  assign sync_o = st_q[SYNC_STAGES-1];
  assign edge_o = sync_o & ~prev_q;

endmodule

// File: rtl/cnt_clk_in_rx.sv
// cnt_clk_in_rx: divided-clock bus receiver with tick counter and lock FSM.
// Define CNT_CLK_IN_PERIOD_CHECK_EN to compile in the edge-interval checker.
module cnt_clk_in_rx
  import cnt_clk_pkg::*;
#(
  parameter int PERIOD_TOL  = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              en,
  input  logic [1:0]        cks,
  input  logic [3:0]        clk_in,
  input  logic              cnt_clr,
  input  logic              err_clr,
  output logic              tick,
  output logic [TCNT_W-1:0] tick_cnt,
  output logic              ovf,
  output logic              period_err,
  output logic              locked
);

  state_e            state_q, state_d;
  logic [1:0]        cks_q;
  logic              tick_q, tick_d;
  logic [TCNT_W-1:0] cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic [3:0]        sync_unused;
  logic [3:0]        edg;
  logic              sel_edge;
  logic              cks_chg;

  cnt_clk_in_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk_i (sys_clk),
    .rst_ni(sys_rst_n),
    .line_i(clk_in),
    .sync_o(sync_unused),
    .edge_o(edg)
  );

  assign sel_edge = edg[cks];
  assign cks_chg  = en && (cks != cks_q);

  // Lock FSM: disable and select changes override normal progress
  always_comb begin
    state_d = state_q;
    if (!en) begin
      state_d = IDLE;
    end else if (cks_chg) begin
      state_d = SYNC;
    end else begin
      unique case (state_q)
        IDLE:    state_d = SYNC;
        SYNC:    if (sel_edge) state_d = TRACK;
        TRACK:   state_d = TRACK;
        default: state_d = IDLE;
      endcase
    end
  end

  // Tick strobe and wrapping tick counter; clear beats a tick
  always_comb begin
    tick_d = sel_edge && en && (state_q != IDLE);
    cnt_d  = cnt_q;
    ovf_d  = 1'b0;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (tick_q) begin
      cnt_d = cnt_q + TCNT_W'(1);
      ovf_d = &cnt_q;
    end
  end

  // Control and counter registers
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= IDLE;
      cks_q   <= '0;
      tick_q  <= 1'b0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cks_q   <= cks;
      tick_q  <= tick_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

`ifdef CNT_CLK_IN_PERIOD_CHECK_EN
  localparam logic [5:0] TOL = 6'(PERIOD_TOL);

  logic [5:0] ivl_q, ivl_d;
  logic       err_q, err_d;
  logic [5:0] exp_e;
  logic [5:0] dev;
  logic       chk_on;
  logic       err_set;

  // Interval counter and mismatch/timeout detection in TRACK only
  always_comb begin
    exp_e   = exp_interval(cks_q);
    dev     = (ivl_q >= exp_e) ? ivl_q - exp_e : exp_e - ivl_q;
    chk_on  = en && !cks_chg && (state_q == TRACK);
    err_set = 1'b0;
    if (chk_on) begin
      if (sel_edge) err_set = dev > TOL;
      else          err_set = ivl_q == exp_e + TOL + 6'd1;
    end
    ivl_d = ivl_q;
    if (state_q == IDLE)     ivl_d = '0;
    else if (sel_edge)       ivl_d = 6'd1;
    else if (ivl_q != 6'd63) ivl_d = ivl_q + 6'd1;
    err_d = err_set || (err_q && !err_clr);
  end

  // Checker registers
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      ivl_q <= '0;
      err_q <= 1'b0;
    end else begin
      ivl_q <= ivl_d;
      err_q <= err_d;
    end
  end

  assign period_err = err_q;
`else
  localparam int unused_tol = PERIOD_TOL;
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign period_err     = 1'b0;
`endif

  assign tick     = tick_q;
  assign tick_cnt = cnt_q;
  assign ovf      = ovf_q;
  assign locked   = (state_q == TRACK);

endmodule

// File: tb/tb_cnt_clk_in_rx.sv
// tb_cnt_clk_in_rx: scoreboard bench for the divided-clock receiver.
// Expected tick cycles are queued from generated edges and popped per cycle.
module tb_cnt_clk_in_rx;

`ifdef CNT_CLK_IN_PERIOD_CHECK_EN
  localparam int PCHK = 1;
`else
  localparam int PCHK = 0;
`endif

  logic       sys_clk   = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       en        = 1'b0;
  logic [1:0] cks       = 2'd0;
  logic [3:0] clk_in    = 4'd0;
  logic       cnt_clr   = 1'b0;
  logic       err_clr   = 1'b0;
  logic       tick;
  logic [7:0] tick_cnt;
  logic       ovf;
  logic       period_err;
  logic       locked;

  cnt_clk_in_rx #(
    .PERIOD_TOL (0),
    .SYNC_STAGES(2)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .en        (en),
    .cks       (cks),
    .clk_in    (clk_in),
    .cnt_clr   (cnt_clr),
    .err_clr   (err_clr),
    .tick      (tick),
    .tick_cnt  (tick_cnt),
    .ovf       (ovf),
    .period_err(period_err),
    .locked    (locked)
  );

  always #5 sys_clk = ~sys_clk;

  int         nchk = 0;
  int         nerr = 0;
  int         cyc = 0;
  int         ntick = 0;
  int         novf = 0;
  int         last_tick = 0;
  int         sbq[$];
  logic       mdl_en_q = 1'b0;
  logic [3:0] rh0 = '0, rh1 = '0, rh2 = '0;
  logic [3:0] dcnt = '0;
  logic [3:0] stop = '0;
  logic       gen_run = 1'b0;

  task automatic chk(input string tag, input int got, input int exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One sys_clk cycle: queue the tick due at the next edge, then drive lines.
  // A line rise driven in cycle m is seen as an edge two edges later.
  task automatic step();
    logic [3:0] line;
    if (mdl_en_q && en && sys_rst_n && rh2[cks]) sbq.push_back(cyc + 1);
    mdl_en_q = en && sys_rst_n;
    @(posedge sys_clk);
    cyc++;
    #1;
    if (gen_run) dcnt = dcnt + 4'd1;
    line   = dcnt & ~stop;
    rh2    = rh1;
    rh1    = rh0;
    rh0    = line & ~clk_in;
    clk_in = line;
  endtask

  task automatic wait_ticks(input int n, input int budget, input string tag);
    int b = 0;
    while (ntick < n && b < budget) begin
      step();
      b++;
    end
    if (ntick < n) chk(tag, ntick, n);
  endtask

  task automatic wait_lock(input int budget, input string tag);
    int b = 0;
    while (!locked && b < budget) begin
      step();
      b++;
    end
    chk(tag, locked, 1);
  endtask

  // Scoreboard: every cycle either a queued tick is due or none may appear
  always @(negedge sys_clk) begin
    if (sbq.size() > 0 && sbq[0] == cyc) begin
      void'(sbq.pop_front());
      chk("tick_due", tick, 1);
    end else begin
      chk("tick_none", tick, 0);
    end
    if (tick) begin
      ntick++;
      last_tick = cyc;
    end
    if (ovf) begin
      novf++;
      chk("ovf_wrap_cnt", tick_cnt, 0);
    end
  end

  initial begin
    int   c0;
    int   err_cyc;
    logic found;

    en  = 1'b1;
    cks = 2'd0;
    repeat (3) step();
    chk("rst_tick", tick, 0);
    chk("rst_cnt", tick_cnt, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_err", period_err, 0);
    chk("rst_locked", locked, 0);

    sys_rst_n = 1'b1;
    gen_run   = 1'b1;
    wait_ticks(10, 100, "t1_tmo");
    chk("t1_cnt", tick_cnt, 10);
    chk("t1_locked", locked, 1);
    chk("t1_err", period_err, 0);

    cks = 2'd3;
    step();
    chk("t2_unlock", locked, 0);
    wait_lock(60, "t2_lock");
    wait_ticks(ntick + 1, 40, "t2_tmo_a");
    repeat (4) step();
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    ntick   = 0;
    novf    = 0;
    chk("t2_clr", tick_cnt, 0);
    wait_ticks(300, 5200, "t2_tmo_b");
    chk("t2_cnt", tick_cnt, 44);
    chk("t2_ovf", novf, 1);
    chk("t2_err", period_err, 0);

    wait_ticks(ntick + 1, 40, "t3_tmo_a");
    repeat (8) step();
    cks = 2'd1;
    step();
    chk("t3_unlock", locked, 0);
    wait_lock(40, "t3_lock");
    wait_ticks(ntick + 5, 60, "t3_tmo_b");
    chk("t3_locked", locked, 1);
    chk("t3_err", period_err, 0);
    chk("t3_cnt", tick_cnt, ntick % 256);

    cks = 2'd2;
    step();
    wait_lock(60, "t4_lock");
    wait_ticks(ntick + 3, 60, "t4_tmo");
    stop[2] = 1'b1;
    found   = 1'b0;
    err_cyc = 0;
    repeat (40) begin
      step();
      if (period_err && !found) begin
        found   = 1'b1;
        err_cyc = cyc;
      end
    end
    chk("t4_err_set", period_err, PCHK);
    chk("t4_err_delay", found ? err_cyc - last_tick : 0, PCHK * 9);
    chk("t4_track", locked, 1);
    en = 1'b0;
    step();
    step();
    chk("t4_idle", locked, 0);
    chk("t4_err_hold", period_err, PCHK);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("t4_err_clr", period_err, 0);
    stop = '0;
    repeat (4) step();
    en = 1'b1;
    wait_lock(60, "t4_relock");
    wait_ticks(ntick + 4, 80, "t4_tmo_b");
    chk("t4_err_relock", period_err, 0);

    cks = 2'd0;
    step();
    wait_lock(40, "t5_lock");
    found = 1'b0;
    for (int i = 0; i < 1200 && !found; i++) begin
      if (tick_cnt == 8'd255 && sbq.size() > 0 && sbq[0] == cyc) found = 1'b1;
      else step();
    end
    chk("t5_align", found, 1);
    chk("t5_at255", tick_cnt, 255);
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    ntick   = 0;
    chk("t5_clr", tick_cnt, 0);
    chk("t5_no_ovf", ovf, 0);
    en = 1'b0;
    step();
    step();
    c0 = tick_cnt;
    c0 = c0 + 0;
    repeat (20) step();
    chk("t5_hold", tick_cnt, c0);
    chk("t5_idle", locked, 0);

    en = 1'b1;
    step();
    wait_lock(40, "t6_lock");
    wait_ticks(ntick + 5, 40, "t6_tmo");
    #1;
    sys_rst_n = 1'b0;
    sbq.delete();
    gen_run  = 1'b0;
    dcnt     = '0;
    stop     = '0;
    clk_in   = '0;
    rh0      = '0;
    rh1      = '0;
    rh2      = '0;
    mdl_en_q = 1'b0;
    #1;
    chk("t6_rst_tick", tick, 0);
    chk("t6_rst_cnt", tick_cnt, 0);
    chk("t6_rst_ovf", ovf, 0);
    chk("t6_rst_err", period_err, 0);
    chk("t6_rst_locked", locked, 0);
    repeat (3) step();
    sys_rst_n = 1'b1;
    gen_run   = 1'b1;
    ntick     = 0;
    step();
    chk("t6_sync", locked, 0);
    wait_lock(40, "t6_relock");
    wait_ticks(6, 60, "t6_tmo_b");
    chk("t6_err", period_err, 0);
    chk("t6_cnt", tick_cnt, ntick);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
